// File: rtl/video_color_pkg.sv
// video_color_pkg: shared colour-space constants and the round/clamp helper for Rx stream stages.
package video_color_pkg;
  localparam int FRAC = 8;
  localparam int CW = 8;
  localparam int OFF_Y = 16;
  localparam int OFF_C = 128;
  localparam int KF_Y = 256;
  localparam int KF_RCR = 359;
  localparam int KF_GCB = 88;
  localparam int KF_GCR = 183;
  localparam int KF_BCB = 454;
  localparam int KL_Y = 298;
  localparam int KL_RCR = 409;
  localparam int KL_GCB = 100;
  localparam int KL_GCR = 208;
  localparam int KL_BCB = 516;

  // Round to nearest, drop the fraction, then saturate to 0..255.
  function automatic logic [CW-1:0] clamp8(input logic signed [20:0] s);
    logic signed [20:0] t;
    t = (s + 21'sd128) >>> FRAC;
    return t[20] ? '0 : (|t[19:CW] ? '1 : t[CW-1:0]);
  endfunction
endpackage

// File: rtl/axis_video_fifo.sv
// axis_video_fifo: show-ahead FIFO for stream beats with a separate occupancy count.
module axis_video_fifo #(
  parameter int W = 26,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         wr_en_i,
  input  logic [W-1:0]                 wr_data_i,
  input  logic                         rd_en_i,
  output logic [W-1:0]                 rd_data_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CNW = $clog2(DEPTH + 1);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CNW-1:0] count_q;
  logic wr, rd;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign wr = wr_en_i & (count_q != CNW'(DEPTH));
  assign rd = rd_en_i & !empty_o;
  // Output forced to zero while empty so reset and idle show a clean bus.
  assign rd_data_o = empty_o ? '0 : mem_q[rd_q];
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      if (wr) wr_q <= nxt(wr_q);
      if (rd) rd_q <= nxt(rd_q);
      count_q <= count_q + CNW'(wr) - CNW'(rd);
    end
  always_ff @(posedge clk)
    if (wr) mem_q[wr_q] <= wr_data_i;
endmodule

// File: rtl/ycbcr_to_rgb.sv
// ycbcr_to_rgb: AXI4-Stream {Cr,Cb,Y} -> {R,B,G} decoder, 2-stage matrix, clamp, credit-flowed output FIFO.
// Define YCBCR2RGB_LIMITED_RANGE_EN for BT.601 studio-range input.
module ycbcr_to_rgb
  import video_color_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int K_Y = 256,
  parameter int K_RCR = 359,
  parameter int K_GCB = 88,
  parameter int K_GCR = 183,
  parameter int K_BCB = 454
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [23:0] s_axis_video_tdata,
  input  logic        s_axis_video_tvalid,
  output logic        s_axis_video_tready,
  input  logic        s_axis_video_tlast,
  input  logic        s_axis_video_tuser,
  output logic [23:0] m_axis_video_tdata,
  output logic        m_axis_video_tvalid,
  input  logic        m_axis_video_tready,
  output logic        m_axis_video_tlast,
  output logic        m_axis_video_tuser
);
  localparam int CNW = $clog2(FIFO_DEPTH + 1);
`ifdef YCBCR2RGB_LIMITED_RANGE_EN
  localparam int YOFF = OFF_Y;
  localparam logic signed [18:0] KY = 19'(KL_Y), KRCR = 19'(KL_RCR), KGCB = 19'(KL_GCB),
                                 KGCR = 19'(KL_GCR), KBCB = 19'(KL_BCB);
`else
  localparam int YOFF = 0;
  localparam logic signed [18:0] KY = 19'(K_Y), KRCR = 19'(K_RCR), KGCB = 19'(K_GCB),
                                 KGCR = 19'(K_GCR), KBCB = 19'(K_BCB);
`endif
  logic s_tready_q, s_tready_d, v1_q, last1_q, user1_q, acc, rd, empty;
  logic signed [8:0] y_s, cb_s, cr_s;
  logic signed [18:0] py_d, prcr_d, pgcb_d, pgcr_d, pbcb_d;
  logic signed [18:0] py_q, prcr_q, pgcb_q, pgcr_q, pbcb_q;
  logic signed [20:0] r_sum, g_sum, b_sum;
  logic [25:0] wr_data, rd_data;
  logic [CNW-1:0] count;
  int o_next;
  assign acc = s_axis_video_tvalid & s_tready_q;
  assign y_s = $signed({1'b0, s_axis_video_tdata[7:0]} - 9'(YOFF));
  assign cb_s = $signed({1'b0, s_axis_video_tdata[15:8]} - 9'(OFF_C));
  assign cr_s = $signed({1'b0, s_axis_video_tdata[23:16]} - 9'(OFF_C));
  assign py_d = 19'(y_s) * KY;
  assign prcr_d = 19'(cr_s) * KRCR;
  assign pgcb_d = 19'(cb_s) * KGCB;
  assign pgcr_d = 19'(cr_s) * KGCR;
  assign pbcb_d = 19'(cb_s) * KBCB;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      v1_q <= 1'b0;
      last1_q <= 1'b0;
      user1_q <= 1'b0;
      py_q <= '0;
      prcr_q <= '0;
      pgcb_q <= '0;
      pgcr_q <= '0;
      pbcb_q <= '0;
      s_tready_q <= 1'b0;
    end else begin
      v1_q <= acc;
      last1_q <= s_axis_video_tlast;
      user1_q <= s_axis_video_tuser;
      py_q <= py_d;
      prcr_q <= prcr_d;
      pgcb_q <= pgcb_d;
      pgcr_q <= pgcr_d;
      pbcb_q <= pbcb_d;
      s_tready_q <= s_tready_d;
    end
  assign r_sum = 21'(py_q) + 21'(prcr_q);
  assign g_sum = 21'(py_q) - 21'(pgcb_q) - 21'(pgcr_q);
  assign b_sum = 21'(py_q) + 21'(pbcb_q);
  assign wr_data = {user1_q, last1_q, clamp8(r_sum), clamp8(b_sum), clamp8(g_sum)};
  axis_video_fifo #(.W(26), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .wr_en_i  (v1_q),
    .wr_data_i(wr_data),
    .rd_en_i  (rd),
    .rd_data_o(rd_data),
    .empty_o  (empty),
    .count_o  (count)
  );
  assign rd = m_axis_video_tvalid & m_axis_video_tready;
  // Credit covers the beat in S1 plus FIFO occupancy so the FIFO can never overflow.
  always_comb begin
    o_next = int'(count) + int'(v1_q) - int'(rd) + int'(acc);
    s_tready_d = o_next < FIFO_DEPTH;
  end
  assign m_axis_video_tvalid = !empty;
  assign {m_axis_video_tuser, m_axis_video_tlast, m_axis_video_tdata} = rd_data;
  assign s_axis_video_tready = s_tready_q;
endmodule

// File: tb/tb_ycbcr_to_rgb.sv
// tb_ycbcr_to_rgb: directed-vector bench for ycbcr_to_rgb with an output scoreboard.
module tb_ycbcr_to_rgb;
  logic clk = 1'b0, rstn = 1'b0;
  logic [23:0] s_tdata = '0, m_tdata;
  logic s_tvalid = 1'b0, s_tready, s_tlast = 1'b0, s_tuser = 1'b0;
  logic m_tvalid, m_tready = 1'b1, m_tlast, m_tuser;
  int n_cmp = 0, n_err = 0, nout = 0;
  bit rnd_rdy = 1'b0;
  logic [23:0] cur_exp;
  logic [25:0] expq[$];
`ifdef YCBCR2RGB_LIMITED_RANGE_EN
  logic [23:0] vin[5] = '{24'h808010, 24'h8080EB, 24'h808080, 24'h808000, 24'h8080FF};
  logic [23:0] vexp[5] = '{24'h000000, 24'hFFFFFF, 24'h828282, 24'h000000, 24'hFFFFFF};
`else
  logic [23:0] vin[5] = '{24'h808080, 24'hFF80FF, 24'h800000, 24'h00FF10, 24'hA06064};
  logic [23:0] vexp[5] = '{24'h808080, 24'hFFFFA4, 24'h00002C, 24'h00F140, 24'h912B58};
`endif

  ycbcr_to_rgb dut (
    .clk                (clk),
    .rstn               (rstn),
    .s_axis_video_tdata (s_tdata),
    .s_axis_video_tvalid(s_tvalid),
    .s_axis_video_tready(s_tready),
    .s_axis_video_tlast (s_tlast),
    .s_axis_video_tuser (s_tuser),
    .m_axis_video_tdata (m_tdata),
    .m_axis_video_tvalid(m_tvalid),
    .m_axis_video_tready(m_tready),
    .m_axis_video_tlast (m_tlast),
    .m_axis_video_tuser (m_tuser)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk)
    if (m_tvalid && m_tready) begin
      if (expq.size() == 0) check("spur_out", 32'(m_tvalid), 0);
      else check("out", {m_tuser, m_tlast, m_tdata}, expq.pop_front());
      nout++;
    end

  task automatic set_beat(input int i, input int n);
    s_tdata = vin[i % 5];
    cur_exp = vexp[i % 5];
    s_tuser = (i == 0);
    s_tlast = (i == n - 1);
  endtask

  task automatic step(output bit a);
    @(negedge clk);
    #1;
    a = s_tvalid && s_tready;
    if (a) expq.push_back({s_tuser, s_tlast, cur_exp});
    @(posedge clk);
    #1;
    if (rnd_rdy) m_tready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic drain(input string tag);
    int k = 0;
    s_tvalid = 1'b0;
    while (expq.size() != 0 && k < 500) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(tag, expq.size(), 0);
  endtask

  initial begin
    bit a;
    int idx, k, n0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy", s_tready, 0);
    check("rst_vld", m_tvalid, 0);
    check("rst_dat", m_tdata, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("rdy_rise", s_tready, 1);
    // single beats: latency and value
    for (int i = 0; i < 5; i++) begin
      set_beat(i, 5);
      s_tvalid = 1'b1;
      step(a);
      s_tvalid = 1'b0;
      check("acc", a, 1);
      check("lat0", m_tvalid, 0);
      @(posedge clk);
      #1;
      check("lat1", m_tvalid, 1);
      check("dat", m_tdata, vexp[i]);
      step(a);
    end
    // backpressure: credit stops at FIFO depth
    m_tready = 1'b0;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      set_beat(idx, 8);
      s_tvalid = 1'b1;
      step(a);
      if (a) idx++;
    end
    check("bp_acc", idx, 4);
    check("bp_rdy", s_tready, 0);
    check("bp_vld", m_tvalid, 1);
    check("bp_hold", m_tdata, vexp[0]);
    n0 = nout;
    m_tready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      set_beat(idx, 8);
      step(a);
      if (a) idx++;
    end
    check("bp_rate", nout - n0, 4);
    k = 0;
    while (idx < 8 && k < 50) begin
      set_beat(idx, 8);
      step(a);
      if (a) idx++;
      k++;
    end
    check("bp_cnt", idx, 8);
    drain("bp_drain");
    // full line with random downstream readiness
    n0 = nout;
    rnd_rdy = 1'b1;
    idx = 0;
    k = 0;
    while (idx < 1920 && k < 20000) begin
      set_beat(idx, 1920);
      s_tvalid = 1'b1;
      step(a);
      if (a) idx++;
      k++;
    end
    check("line_acc", idx, 1920);
    drain("line_drain");
    rnd_rdy = 1'b0;
    m_tready = 1'b1;
    check("line_out", nout - n0, 1920);
    // reset with beats in flight
    m_tready = 1'b0;
    idx = 0;
    k = 0;
    while (idx < 3 && k < 20) begin
      set_beat(idx, 3);
      s_tvalid = 1'b1;
      step(a);
      if (a) idx++;
      k++;
    end
    s_tvalid = 1'b0;
    rstn = 1'b0;
    #1;
    check("rst6_vld", m_tvalid, 0);
    check("rst6_rdy", s_tready, 0);
    check("rst6_dat", m_tdata, 0);
    expq.delete();
    n0 = nout;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    m_tready = 1'b1;
    @(posedge clk);
    #1;
    check("rst6_rise", s_tready, 1);
    repeat (8) step(a);
    check("rst6_drop", nout - n0, 0);
    check("rst6_idle", m_tvalid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
